// File: rtl/mips_exc_pkg.sv
// Shared definitions for the exception sequencer and CP0: FSM states, Cause
// select codes and the architectural CP0 register indices.
package mips_exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_CAUSE = 3'd1,
    ST_WR_EPC   = 3'd2,
    ST_VECTOR   = 3'd3,
    ST_RD_EPC   = 3'd4,
    ST_RETURN   = 3'd5,
    ST_MTC0     = 3'd6
  } exc_state_e;

  // CP0 turns the first three codes into fixed ExcCode values; SEL_WR writes cp0_wdata.
  localparam logic [1:0] SEL_OVF   = 2'b00;
  localparam logic [1:0] SEL_UNDEF = 2'b01;
  localparam logic [1:0] SEL_DIV0  = 2'b10;
  localparam logic [1:0] SEL_WR    = 2'b11;

  localparam logic [4:0] CAUSE_REG = 5'd13;
  localparam logic [4:0] EPC_REG   = 5'd14;

endpackage

// File: rtl/mips_exc_prio_enc.sv
// Fault-flag priority encoder: undef > ovf > div0.
// Purely combinational; exc_vld is set when any flag is raised.
module mips_exc_prio_enc
  import mips_exc_pkg::*;
(
  input  logic       undef,
  input  logic       ovf,
  input  logic       div0,
  output logic       exc_vld,
  output logic [1:0] exc_sel
);

  always_comb begin
    exc_vld = undef | ovf | div0;
    exc_sel = SEL_OVF;
    if (undef) begin
      exc_sel = SEL_UNDEF;
    end else if (ovf) begin
      exc_sel = SEL_OVF;
    end else if (div0) begin
      exc_sel = SEL_DIV0;
    end
  end

endmodule

// File: rtl/mips_exception_ctrl.sv
// Exception/eret/mtc0 sequencer owning the CP0 write/read port; outputs are registered.
// Exception 3 cycles (2 when nested), eret 2, mtc0 1; stall holds the main FSM meanwhile.
module mips_exception_ctrl
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  parameter logic [4:0]  CAUSE_REG    = mips_exc_pkg::CAUSE_REG,
  parameter logic [4:0]  EPC_REG      = mips_exc_pkg::EPC_REG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ovf,
  input  logic        undef,
  input  logic        div0,
  input  logic        eret,
  input  logic        mtc0,
  input  logic [4:0]  mtc0_rd,
  input  logic [31:0] mtc0_data,
  input  logic [31:0] exc_pc,
  input  logic [31:0] cp0_rdata,
  output logic        cp0_write,
  output logic [4:0]  cp0_rd,
  output logic [1:0]  cp0_cause_sel,
  output logic [31:0] cp0_wdata,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        stall,
  output logic        exl
);

  exc_state_e  state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;

  logic        cp0_write_q, cp0_write_d;
  logic [4:0]  cp0_rd_q, cp0_rd_d;
  logic [1:0]  cp0_cause_sel_q, cp0_cause_sel_d;
  logic [31:0] cp0_wdata_q, cp0_wdata_d;
  logic        pc_redirect_q, pc_redirect_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        stall_q, stall_d;

  logic        exc_vld;
  logic [1:0]  exc_sel;

  mips_exc_prio_enc u_prio_enc (
    .undef   (undef),
    .ovf     (ovf),
    .div0    (div0),
    .exc_vld (exc_vld),
    .exc_sel (exc_sel)
  );

  // Next-state logic; request inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    exl_d   = exl_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_vld) begin
          state_d = ST_WR_CAUSE;
          cause_d = exc_sel;
          pc_d    = exc_pc;
        end else if (eret) begin
          if (exl_q) begin
            state_d = ST_RD_EPC;
          end else begin
            state_d = ST_WR_CAUSE;
            cause_d = SEL_UNDEF;
            pc_d    = exc_pc;
          end
        end else if (mtc0) begin
          state_d = ST_MTC0;
        end
      end
      // A nested exception keeps the original EPC.
      ST_WR_CAUSE: state_d = exl_q ? ST_VECTOR : ST_WR_EPC;
      ST_WR_EPC:   state_d = ST_VECTOR;
      ST_VECTOR: begin
        exl_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_EPC: begin
        epc_d   = cp0_rdata;
        state_d = ST_RETURN;
      end
      ST_RETURN: begin
        exl_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_MTC0:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    cp0_write_d     = 1'b0;
    cp0_rd_d        = 5'd0;
    cp0_cause_sel_d = SEL_WR;
    cp0_wdata_d     = 32'd0;
    pc_redirect_d   = 1'b0;
    pc_target_d     = 32'd0;
    stall_d         = (state_d != ST_IDLE);
    case (state_d)
      ST_WR_CAUSE: begin
        cp0_write_d     = 1'b1;
        cp0_rd_d        = CAUSE_REG;
        cp0_cause_sel_d = cause_d;
      end
      ST_WR_EPC: begin
        cp0_write_d = 1'b1;
        cp0_rd_d    = EPC_REG;
        cp0_wdata_d = pc_d;
      end
      ST_VECTOR: begin
        pc_redirect_d = 1'b1;
        pc_target_d   = HANDLER_ADDR;
      end
      ST_RD_EPC: begin
        cp0_rd_d = EPC_REG;
      end
      ST_RETURN: begin
        pc_redirect_d = 1'b1;
        pc_target_d   = epc_d;
      end
      ST_MTC0: begin
        cp0_write_d = 1'b1;
        cp0_rd_d    = mtc0_rd;
        cp0_wdata_d = mtc0_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cause_q         <= 2'b00;
      pc_q            <= 32'd0;
      epc_q           <= 32'd0;
      exl_q           <= 1'b0;
      cp0_write_q     <= 1'b0;
      cp0_rd_q        <= 5'd0;
      cp0_cause_sel_q <= SEL_WR;
      cp0_wdata_q     <= 32'd0;
      pc_redirect_q   <= 1'b0;
      pc_target_q     <= 32'd0;
      stall_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cause_q         <= cause_d;
      pc_q            <= pc_d;
      epc_q           <= epc_d;
      exl_q           <= exl_d;
      cp0_write_q     <= cp0_write_d;
      cp0_rd_q        <= cp0_rd_d;
      cp0_cause_sel_q <= cp0_cause_sel_d;
      cp0_wdata_q     <= cp0_wdata_d;
      pc_redirect_q   <= pc_redirect_d;
      pc_target_q     <= pc_target_d;
      stall_q         <= stall_d;
    end
  end

  assign cp0_write     = cp0_write_q;
  assign cp0_rd        = cp0_rd_q;
  assign cp0_cause_sel = cp0_cause_sel_q;
  assign cp0_wdata     = cp0_wdata_q;
  assign pc_redirect   = pc_redirect_q;
  assign pc_target     = pc_target_q;
  assign stall         = stall_q;
  assign exl           = exl_q;

endmodule

// File: tb/tb_mips_exception_ctrl.sv
// Randomized bench: per-cycle expectations are derived from the request rules and
// compared every cycle; a small CP0 register array answers the read port.
module tb_mips_exception_ctrl;

  localparam logic [31:0] HANDLER = 32'h8000_0180;

  logic        clk, rst;
  logic        ovf, undef, div0, eret, mtc0;
  logic [4:0]  mtc0_rd;
  logic [31:0] mtc0_data, exc_pc, cp0_rdata;
  logic        cp0_write, pc_redirect, stall, exl;
  logic [4:0]  cp0_rd;
  logic [1:0]  cp0_cause_sel;
  logic [31:0] cp0_wdata, pc_target;

  mips_exception_ctrl dut (
    .clk(clk), .rst(rst), .ovf(ovf), .undef(undef), .div0(div0), .eret(eret),
    .mtc0(mtc0), .mtc0_rd(mtc0_rd), .mtc0_data(mtc0_data), .exc_pc(exc_pc),
    .cp0_rdata(cp0_rdata), .cp0_write(cp0_write), .cp0_rd(cp0_rd),
    .cp0_cause_sel(cp0_cause_sel), .cp0_wdata(cp0_wdata),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .stall(stall), .exl(exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CP0 register file seen by the DUT.
  logic [31:0] cp0_mem [32];
  assign cp0_rdata = cp0_mem[cp0_rd];

  function automatic logic [31:0] exc_code(input logic [1:0] s);
    case (s)
      2'b00:   return 32'd48;
      2'b01:   return 32'd40;
      default: return 32'd36;
    endcase
  endfunction

  always @(posedge clk)
    if (!rst && cp0_write)
      cp0_mem[cp0_rd] <= (cp0_cause_sel == 2'b11) ? cp0_wdata : exc_code(cp0_cause_sel);

  int          redir_cnt = 0;
  logic [31:0] last_tgt = 32'd0;
  always @(negedge clk)
    if (pc_redirect) begin
      redir_cnt++;
      last_tgt = pc_target;
    end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, expv);
    end
  endtask

  typedef struct {
    logic        stall, wr, redir, exl;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] wdata, tgt;
    bit          c_rd, c_sel, c_wd, c_tg;
  } exp_t;

  exp_t exp_q [int];
  bit   chk_en = 1'b0;
  exp_t ce;

  function automatic exp_t mk(input logic st, input logic wr, input logic rx, input logic x,
                              input bit crd, input logic [4:0] rd, input bit csel,
                              input logic [1:0] sel, input bit cwd, input logic [31:0] wd,
                              input bit ctg, input logic [31:0] tg);
    exp_t e;
    e.stall = st; e.wr = wr; e.redir = rx; e.exl = x;
    e.c_rd = crd; e.rd = rd; e.c_sel = csel; e.sel = sel;
    e.c_wd = cwd; e.wdata = wd; e.c_tg = ctg; e.tgt = tg;
    return e;
  endfunction

  function automatic exp_t idle_e(input logic x);
    return mk(1'b0, 1'b0, 1'b0, x, 1'b0, 5'd0, 1'b1, 2'b11, 1'b0, 32'd0, 1'b0, 32'd0);
  endfunction

  // Single per-cycle compare process.
  always @(negedge clk)
    if (chk_en && exp_q.exists(cyc)) begin
      ce = exp_q[cyc];
      chk("stall", 32'(stall), 32'(ce.stall));
      chk("cp0_write", 32'(cp0_write), 32'(ce.wr));
      chk("pc_redirect", 32'(pc_redirect), 32'(ce.redir));
      chk("exl", 32'(exl), 32'(ce.exl));
      if (ce.c_rd)  chk("cp0_rd", 32'(cp0_rd), 32'(ce.rd));
      if (ce.c_sel) chk("cp0_cause_sel", 32'(cp0_cause_sel), 32'(ce.sel));
      if (ce.c_wd)  chk("cp0_wdata", cp0_wdata, ce.wdata);
      if (ce.c_tg)  chk("pc_target", pc_target, ce.tgt);
    end

  // Reference state.
  logic        exl_m = 1'b0;
  logic [31:0] epc_m = 32'd0;

  task automatic clear_in();
    ovf = 1'b0; undef = 1'b0; div0 = 1'b0; eret = 1'b0; mtc0 = 1'b0;
    mtc0_rd = 5'd0; mtc0_data = 32'd0; exc_pc = 32'd0;
  endtask

  // Called one time unit after a rising edge in an IDLE cycle whose expectation exists.
  task automatic issue(input logic i_ovf, input logic i_undef, input logic i_div0,
                       input logic i_eret, input logic i_mtc0, input logic [4:0] i_rd,
                       input logic [31:0] i_data, input logic [31:0] i_pc, input bit noise);
    exp_t       s[$];
    logic [1:0] sel;
    bit         exc;
    int         c;
    c = cyc;
    ovf = i_ovf; undef = i_undef; div0 = i_div0; eret = i_eret; mtc0 = i_mtc0;
    mtc0_rd = i_rd; mtc0_data = i_data; exc_pc = i_pc;

    exc = i_undef || i_ovf || i_div0 || (i_eret && !exl_m);
    sel = i_undef ? 2'b01 : i_ovf ? 2'b00 : i_div0 ? 2'b10 : 2'b01;
    if (exc) begin
      s.push_back(mk(1, 1, 0, exl_m, 1, 5'd13, 1, sel, 0, 32'd0, 0, 32'd0));
      if (!exl_m) begin
        s.push_back(mk(1, 1, 0, exl_m, 1, 5'd14, 1, 2'b11, 1, i_pc, 0, 32'd0));
        epc_m = i_pc;
      end
      s.push_back(mk(1, 0, 1, exl_m, 0, 5'd0, 0, 2'b11, 0, 32'd0, 1, HANDLER));
      exl_m = 1'b1;
    end else if (i_eret) begin
      s.push_back(mk(1, 0, 0, exl_m, 1, 5'd14, 0, 2'b11, 0, 32'd0, 0, 32'd0));
      s.push_back(mk(1, 0, 1, exl_m, 0, 5'd0, 0, 2'b11, 0, 32'd0, 1, epc_m));
      exl_m = 1'b0;
    end else if (i_mtc0) begin
      s.push_back(mk(1, 1, 0, exl_m, 1, i_rd, 1, 2'b11, 1, i_data, 0, 32'd0));
      if (i_rd == 5'd14) epc_m = i_data;
    end
    for (int i = 0; i < s.size(); i++) exp_q[c + 1 + i] = s[i];
    exp_q[c + 1 + s.size()] = idle_e(exl_m);

    for (int i = 0; i <= s.size(); i++) begin
      @(posedge clk); #1;
      if (noise && i < s.size()) begin
        ovf = 1'($urandom_range(0, 1)); undef = 1'($urandom_range(0, 1));
        div0 = 1'($urandom_range(0, 1)); eret = 1'($urandom_range(0, 1));
        mtc0 = 1'($urandom_range(0, 1)); mtc0_rd = 5'($urandom);
        mtc0_data = $urandom; exc_pc = $urandom;
      end else begin
        clear_in();
      end
    end
  endtask

  int rbase;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) cp0_mem[i] = 32'd0;
    clear_in();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_cp0_write", 32'(cp0_write), 32'd0);
    chk("rst_cp0_rd", 32'(cp0_rd), 32'd0);
    chk("rst_sel", 32'(cp0_cause_sel), 32'd3);
    chk("rst_wdata", cp0_wdata, 32'd0);
    chk("rst_redirect", 32'(pc_redirect), 32'd0);
    chk("rst_target", pc_target, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_exl", 32'(exl), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q[cyc] = idle_e(1'b0);
    chk_en = 1'b1;

    // Overflow from exl=0: full three-cycle path.
    rbase = redir_cnt;
    issue(1, 0, 0, 0, 0, 5'd0, 32'd0, 32'h0040_0010, 0);
    chk("ovf_redir_count", 32'(redir_cnt - rbase), 32'd1);
    chk("ovf_redir_tgt", last_tgt, 32'h8000_0180);
    chk("ovf_cause", cp0_mem[13], 32'd48);
    chk("ovf_epc", cp0_mem[14], 32'h0040_0010);
    chk("ovf_exl", 32'(exl), 32'd1);

    // Nested: priority among simultaneous flags, EPC left alone.
    issue(1, 1, 1, 0, 0, 5'd0, 32'd0, 32'h0040_0100, 0);
    chk("all3_cause", cp0_mem[13], 32'd40);
    issue(1, 0, 1, 0, 0, 5'd0, 32'd0, 32'h0040_0104, 0);
    chk("ovfdiv_cause", cp0_mem[13], 32'd48);
    issue(0, 0, 1, 0, 0, 5'd0, 32'd0, 32'h0040_0108, 0);
    chk("div0_cause", cp0_mem[13], 32'd36);
    chk("nested_epc", cp0_mem[14], 32'h0040_0010);

    // eret returns to EPC; a second eret becomes an undefined-opcode exception.
    issue(0, 0, 0, 0, 1, 5'd14, 32'h0040_0020, 32'd0, 0);
    issue(0, 0, 0, 1, 0, 5'd0, 32'd0, 32'h0040_0200, 0);
    chk("eret_tgt", last_tgt, 32'h0040_0020);
    chk("eret_exl", 32'(exl), 32'd0);
    issue(0, 0, 0, 1, 0, 5'd0, 32'd0, 32'h0040_0030, 0);
    chk("eret0_cause", cp0_mem[13], 32'd40);
    chk("eret0_epc", cp0_mem[14], 32'h0040_0030);
    chk("eret0_exl", 32'(exl), 32'd1);

    issue(0, 0, 0, 0, 1, 5'd12, 32'hDEAD_BEEF, 32'd0, 0);
    chk("mtc0_r12", cp0_mem[12], 32'hDEAD_BEEF);
    issue(1, 0, 0, 0, 1, 5'd5, 32'h1234_5678, 32'h0040_0300, 0);
    chk("mtc0_dropped", cp0_mem[5], 32'd0);
    chk("mtc0_ovf_cause", cp0_mem[13], 32'd48);

    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [2:0] f;
      logic [4:0] rd;
      r  = $urandom_range(0, 9);
      f  = 3'($urandom_range(1, 7));
      rd = ($urandom_range(0, 3) == 0) ? 5'd14 : 5'($urandom);
      if (r < 4)
        issue(f[0], f[1], f[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rd, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1);
      else if (r < 6)
        issue(0, 0, 0, 1, 1'($urandom_range(0, 1)), rd, $urandom, $urandom & ~32'd3, 1);
      else if (r < 9)
        issue(0, 0, 0, 0, 1, rd, $urandom, $urandom, 1);
      else
        issue(0, 0, 0, 0, 0, rd, $urandom, $urandom, 1);
    end

    // Reset in the middle of WR_EPC.
    if (exl_m) issue(0, 0, 0, 1, 0, 5'd0, 32'd0, 32'd0, 0);
    chk_en = 1'b0;
    ovf = 1'b1; exc_pc = 32'h0040_0400;
    @(posedge clk); #1;
    clear_in();
    @(posedge clk); #1;
    chk("pre_rst_write", 32'(cp0_write), 32'd1);
    chk("pre_rst_rd", 32'(cp0_rd), 32'd14);
    #2 rst = 1'b1;
    #1;
    rbase = redir_cnt;
    chk("arst_cp0_write", 32'(cp0_write), 32'd0);
    chk("arst_cp0_rd", 32'(cp0_rd), 32'd0);
    chk("arst_sel", 32'(cp0_cause_sel), 32'd3);
    chk("arst_wdata", cp0_wdata, 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_redirect", 32'(pc_redirect), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_redirect", 32'(redir_cnt - rbase), 32'd0);
    chk("arst_exl", 32'(exl), 32'd0);
    chk("arst_idle", 32'(stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
